// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the multi-channel sequence generator.
package seq_gen_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;
  localparam int MODE_W    = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } seq_mode_e;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] start;
    logic signed [DEF_WIDTH-1:0] step;
    logic signed [DEF_WIDTH-1:0] lo;
    logic signed [DEF_WIDTH-1:0] hi;
    seq_mode_e                   mode;
  } seq_chan_cfg_t;

endpackage

// File: rtl/seq_gen_next.sv
// Per-channel successor value: cur + step with WRAP / SATURATE / BOUNCE handling.
// BOUNCE (and step negation) exists only when SEQ_GEN_MC_BOUNCE_EN is defined.
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] cur_i,
  input  logic signed [WIDTH-1:0] step_i,
  input  logic signed [WIDTH-1:0] min_i,
  input  logic signed [WIDTH-1:0] max_i,
  input  seq_mode_e               mode_i,
  output logic signed [WIDTH-1:0] next_o,
  output logic signed [WIDTH-1:0] next_step_o,
  output logic                    hit_done_o
);

  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH:0]   min_x;
  logic signed [WIDTH:0]   max_x;
  logic                    over_hi;
  logic                    over_lo;
  logic signed [WIDTH-1:0] bound;
  logic                    at_bound;

  // one extra bit so cur + step never aliases
  assign sum      = {cur_i[WIDTH-1], cur_i} + {step_i[WIDTH-1], step_i};
  assign min_x    = {min_i[WIDTH-1], min_i};
  assign max_x    = {max_i[WIDTH-1], max_i};
  assign over_hi  = sum > max_x;
  assign over_lo  = sum < min_x;
  assign bound    = over_hi ? max_i : min_i;
  assign at_bound = (cur_i == bound);

`ifdef SEQ_GEN_MC_BOUNCE_EN
  localparam logic signed [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_INT = {1'b0, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0] step_neg;
  logic signed [WIDTH:0]   refl;
  logic signed [WIDTH-1:0] refl_c;

  assign step_neg = (step_i == MIN_INT) ? MAX_INT : -step_i;
  assign refl     = {cur_i[WIDTH-1], cur_i} + {step_neg[WIDTH-1], step_neg};
  assign refl_c   = (refl > max_x) ? max_i : ((refl < min_x) ? min_i : refl[WIDTH-1:0]);
`endif

  // A bound is emitted once; the overshoot from a value already on the bound
  // terminates (SATURATE) or reflects (BOUNCE).
  always_comb begin
    next_o      = sum[WIDTH-1:0];
    next_step_o = step_i;
    hit_done_o  = 1'b0;
    if (over_hi || over_lo) begin
      if (mode_i == MODE_SAT) begin
        next_o     = bound;
        hit_done_o = at_bound;
      end
`ifdef SEQ_GEN_MC_BOUNCE_EN
      else if (mode_i == MODE_BOUNCE) begin
        next_step_o = step_neg;
        next_o      = at_bound ? refl_c : bound;
      end
`endif
      else begin
        next_o = step_i[WIDTH-1] ? max_i : min_i;
      end
    end
  end

endmodule

// File: rtl/seq_gen_mc.sv
// NCH independent arithmetic sequences, round-robin onto one valid/ready stream.
// Build option: SEQ_GEN_MC_BOUNCE_EN enables mode 2 as BOUNCE (otherwise WRAP).
module seq_gen_mc
  import seq_gen_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [CHW-1:0]          cfg_ch,
  input  logic signed [WIDTH-1:0] cfg_start,
  input  logic signed [WIDTH-1:0] cfg_step,
  input  logic signed [WIDTH-1:0] cfg_min,
  input  logic signed [WIDTH-1:0] cfg_max,
  input  logic [1:0]              cfg_mode,
  input  logic [NCH-1:0]          enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch,
  output logic signed [WIDTH-1:0] out_value,
  output logic [NCH-1:0]          done
);

  logic signed [WIDTH-1:0] cur_q  [NCH];
  logic signed [WIDTH-1:0] cur_d  [NCH];
  logic signed [WIDTH-1:0] step_q [NCH];
  logic signed [WIDTH-1:0] step_d [NCH];
  logic signed [WIDTH-1:0] min_q  [NCH];
  logic signed [WIDTH-1:0] min_d  [NCH];
  logic signed [WIDTH-1:0] max_q  [NCH];
  logic signed [WIDTH-1:0] max_d  [NCH];
  seq_mode_e               mode_q [NCH];
  seq_mode_e               mode_d [NCH];
  logic [NCH-1:0]          done_q;
  logic [NCH-1:0]          done_d;

  logic signed [WIDTH-1:0] nxt    [NCH];
  logic signed [WIDTH-1:0] nstep  [NCH];
  logic                    hit    [NCH];

  logic [CHW-1:0]          rr_q;
  logic [CHW-1:0]          rr_d;
  logic                    out_valid_q;
  logic                    out_valid_d;
  logic [CHW-1:0]          out_ch_q;
  logic [CHW-1:0]          out_ch_d;
  logic signed [WIDTH-1:0] out_value_q;
  logic signed [WIDTH-1:0] out_value_d;

  logic                    accept;
  logic [NCH-1:0]          elig_d;
  logic                    hold;
  logic                    found;
  logic [CHW-1:0]          pick;
  int                      k;
  logic signed [WIDTH-1:0] start_clamped;

  assign accept        = out_valid_q & out_ready;
  assign start_clamped = (cfg_start < cfg_min) ? cfg_min :
                         ((cfg_start > cfg_max) ? cfg_max : cfg_start);

  for (genvar c = 0; c < NCH; c++) begin : g_next
    seq_gen_next #(.WIDTH(WIDTH)) u_next (
      .cur_i       (cur_q[c]),
      .step_i      (step_q[c]),
      .min_i       (min_q[c]),
      .max_i       (max_q[c]),
      .mode_i      (mode_q[c]),
      .next_o      (nxt[c]),
      .next_step_o (nstep[c]),
      .hit_done_o  (hit[c])
    );
  end

  // channel state: a cfg write overrides a same-cycle advance
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cur_d[c]  = cur_q[c];
      step_d[c] = step_q[c];
      min_d[c]  = min_q[c];
      max_d[c]  = max_q[c];
      mode_d[c] = mode_q[c];
      done_d[c] = done_q[c];
      if (cfg_we && (cfg_ch == CHW'(c))) begin
        cur_d[c]  = start_clamped;
        step_d[c] = cfg_step;
        min_d[c]  = cfg_min;
        max_d[c]  = cfg_max;
        mode_d[c] = seq_mode_e'(cfg_mode);
        done_d[c] = 1'b0;
      end else if (accept && (out_ch_q == CHW'(c))) begin
        cur_d[c]  = nxt[c];
        step_d[c] = nstep[c];
        done_d[c] = done_q[c] | hit[c];
      end
    end
  end

  // presentation for next cycle, judged on the post-update channel state
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      elig_d[c] = enable[c] & ~done_d[c] & (min_d[c] <= max_d[c]);
    end
    hold  = out_valid_q & ~out_ready & elig_d[out_ch_q];
    rr_d  = rr_q;
    if (accept) begin
      rr_d = (out_ch_q == CHW'(NCH - 1)) ? '0 : out_ch_q + 1'b1;
    end
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(rr_d) + i;
      if (k >= NCH) begin
        k = k - NCH;
      end
      if (!found && elig_d[k]) begin
        found = 1'b1;
        pick  = CHW'(k);
      end
    end
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_value_d = out_value_q;
    if (hold) begin
      out_valid_d = 1'b1;
      out_value_d = cur_d[out_ch_q];
    end else if (found) begin
      out_valid_d = 1'b1;
      out_ch_d    = pick;
      out_value_d = cur_d[pick];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cur_q[c]  <= '0;
        step_q[c] <= '0;
        min_q[c]  <= '0;
        max_q[c]  <= '0;
        mode_q[c] <= MODE_WRAP;
      end
      done_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_value_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cur_q[c]  <= cur_d[c];
        step_q[c] <= step_d[c];
        min_q[c]  <= min_d[c];
        max_q[c]  <= max_d[c];
        mode_q[c] <= mode_d[c];
      end
      done_q      <= done_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_value_q <= out_value_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_value = out_value_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_mc.sv
// Scoreboard bench for seq_gen_mc: per-channel expected-value queues fed from a
// behavioural sequence model, drained by an independent output monitor.
module tb_seq_gen_mc;

  localparam longint MIN32 = -64'sd2147483648;
  localparam longint MAX32 = 64'sd2147483647;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic signed [31:0] cfg_start, cfg_step, cfg_min, cfg_max;
  logic [1:0]         cfg_mode;
  logic [3:0]         enable;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [31:0] out_value;
  logic [3:0]         done;

  logic               cfg8_we;
  logic [0:0]         cfg8_ch;
  logic signed [7:0]  cfg8_start, cfg8_step, cfg8_min, cfg8_max;
  logic [1:0]         cfg8_mode;
  logic [1:0]         enable8;
  logic               valid8;
  logic               ready8;
  logic [0:0]         ch8;
  logic signed [7:0]  value8;
  logic [1:0]         done8;

  always #5 clk = ~clk;

  seq_gen_mc dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_mode(cfg_mode), .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_value(out_value), .done(done)
  );

  seq_gen_mc #(.WIDTH(8), .NCH(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg8_we), .cfg_ch(cfg8_ch),
    .cfg_start(cfg8_start), .cfg_step(cfg8_step), .cfg_min(cfg8_min), .cfg_max(cfg8_max),
    .cfg_mode(cfg8_mode), .enable(enable8), .out_valid(valid8), .out_ready(ready8),
    .out_ch(ch8), .out_value(value8), .done(done8)
  );

  int     n_chk = 0;
  int     n_fail = 0;
  longint exp_q [4][$];
  longint exp8_q [$];
  int     order_q [$];
  int     acc_cnt [4];
  bit     stall_chk = 0;
  bit     prev_stall = 0;
  int     prev_ch;
  longint prev_val;

  // behavioural model state (plain integers, no width aliasing)
  longint m_cur [4], m_step [4], m_min [4], m_max [4];
  int     m_mode [4];
  bit     m_done [4];

  function automatic void chk(string name, longint act, longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  function automatic longint clampv(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_cfg(int ch, longint st, longint sp, longint mn, longint mx, int md);
    m_cur[ch]  = clampv(st, mn, mx);
    m_step[ch] = sp;
    m_min[ch]  = mn;
    m_max[ch]  = mx;
    m_mode[ch] = md;
    m_done[ch] = 0;
  endfunction

  // Successor per the mode rules: a reached bound is emitted once, then the
  // channel finishes (saturate), reflects (bounce) or restarts (wrap).
  function automatic void model_adv(int ch);
    longint nx, bnd;
    bit bounce;
    bounce = 0;
`ifdef SEQ_GEN_MC_BOUNCE_EN
    bounce = (m_mode[ch] == 2);
`endif
    nx = m_cur[ch] + m_step[ch];
    if (nx > m_max[ch] || nx < m_min[ch]) begin
      bnd = (nx > m_max[ch]) ? m_max[ch] : m_min[ch];
      if (m_mode[ch] == 1) begin
        if (m_cur[ch] == bnd) m_done[ch] = 1;
        else m_cur[ch] = bnd;
      end else if (bounce) begin
        m_step[ch] = (m_step[ch] == MIN32) ? MAX32 : -m_step[ch];
        if (m_cur[ch] == bnd) m_cur[ch] = clampv(m_cur[ch] + m_step[ch], m_min[ch], m_max[ch]);
        else m_cur[ch] = bnd;
      end else begin
        m_cur[ch] = (m_step[ch] >= 0) ? m_min[ch] : m_max[ch];
      end
    end else begin
      m_cur[ch] = nx;
    end
  endfunction

  function automatic void push_n(int ch, int n);
    for (int i = 0; i < n; i++) begin
      if (m_done[ch] || m_min[ch] > m_max[ch]) break;
      exp_q[ch].push_back(m_cur[ch]);
      model_adv(ch);
    end
  endfunction

  // monitor: pops the expected value whenever a beat is accepted
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q[out_ch].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat ch%0d: got value %0d expected no beat", out_ch, out_value);
        end else begin
          chk($sformatf("beat_ch%0d", out_ch), longint'(out_value), exp_q[out_ch].pop_front());
        end
        order_q.push_back(int'(out_ch));
        acc_cnt[out_ch]++;
      end
      if (stall_chk && prev_stall && out_valid) begin
        chk("stall_ch", longint'(out_ch), longint'(prev_ch));
        chk("stall_value", longint'(out_value), prev_val);
      end
      prev_stall = out_valid && !out_ready;
      prev_ch    = int'(out_ch);
      prev_val   = longint'(out_value);
      if (valid8 && ready8) begin
        if (exp8_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat8: got value %0d expected no beat", value8);
        end else begin
          chk("beat8", longint'(value8), exp8_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int ch, longint st, longint sp, longint mn, longint mx, int md);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_start = 32'(st);
    cfg_step  = 32'(sp);
    cfg_min   = 32'(mn);
    cfg_max   = 32'(mx);
    cfg_mode  = 2'(md);
    model_cfg(ch, st, sp, mn, mx, md);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain(int ch, int thr, int limit);
    for (int i = 0; i < limit && exp_q[ch].size() > thr; i++) tick();
    chk($sformatf("drain_timeout_ch%0d", ch), exp_q[ch].size() > thr, 0);
  endtask

  task automatic stop_all();
    stall_chk = 0;
    out_ready = 1'b0;
    tick();
    enable = '0;
    tick();
    tick();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    rst_n = 1'b0; cfg_we = 0; cfg_ch = 0; cfg_start = 0; cfg_step = 0; cfg_min = 0;
    cfg_max = 0; cfg_mode = 0; enable = 0; out_ready = 0;
    cfg8_we = 0; cfg8_ch = 0; cfg8_start = 0; cfg8_step = 0; cfg8_min = 0;
    cfg8_max = 0; cfg8_mode = 0; enable8 = 0; ready8 = 0;
    for (int c = 0; c < 4; c++) model_cfg(c, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_ch", out_ch, 0);
    chk("reset_value", out_value, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    tick();

    // basic increment with wrap
    out_ready = 1'b1;
    cfg(0, 0, 3, 0, 10, 0);
    push_n(0, 6);
    enable = 4'b0001;
    wait_drain(0, 1, 50);
    enable = 4'b0000;
    tick(); tick();
    chk("basic_left", exp_q[0].size(), 0);

    // saturate down to the lower bound, then done and silent
    cfg(1, 5, -4, -6, 6, 1);
    push_n(1, 10);
    enable = 4'b0010;
    wait_drain(1, 0, 50);
    repeat (10) tick();
    chk("sat_done", done, 4'b0010);
    chk("sat_valid_low", out_valid, 0);
    enable = 4'b0000;

    // bounce (or wrap when the bounce build option is absent)
    cfg(2, 8, 2, 0, 10, 2);
    push_n(2, 8);
    enable = 4'b0100;
    wait_drain(2, 1, 50);
    enable = 4'b0000;
    tick(); tick();
    chk("bounce_left", exp_q[2].size(), 0);

    // same-cycle cfg write and accepted beat on ch0
    cfg(0, 0, 3, 0, 10, 0);
    push_n(0, 2);
    enable = 4'b0001;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid && out_ch == 0 && out_value == 3) seen = 1;
      end
      chk("samecyc_seen3", seen, 1);
    end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_start = 7; cfg_step = 3; cfg_min = 0; cfg_max = 10; cfg_mode = 0;
    model_cfg(0, 7, 3, 0, 10, 0);
    push_n(0, 3);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_drain(0, 1, 50);
    enable = 4'b0000;
    tick(); tick();
    chk("samecyc_left", exp_q[0].size(), 0);

    // interleave, no bubbles, then random backpressure
    cfg(0, 0, 1, 0, 100, 0);
    cfg(1, 100, -1, 0, 100, 0);
    push_n(0, 40);
    push_n(1, 40);
    order_q.delete();
    out_ready = 1'b1;
    enable = 4'b0011;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("no_bubble", out_valid, 1);
      tick();
    end
    stall_chk = 1;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 == 1) ? 1'b0 : 1'($urandom_range(1, 0));
      tick();
    end
    stall_chk = 0;
    out_ready = 1'b0;
    tick();
    chk("interleave_count", order_q.size() >= 10, 1);
    for (int i = 1; i < order_q.size(); i++) chk("alternate", order_q[i] != order_q[i-1], 1);
    // withdraw the stalled beat by disabling its channel
    p = int'(out_ch);
    chk("stalled_valid", out_valid, 1);
    enable[p] = 1'b0;
    tick();
    chk("withdraw_gone", out_valid && out_ch == 2'(p), 0);
    chk("withdraw_next", out_valid && out_ch != 2'(p), 1);
    stop_all();

    // randomized channels against the model
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        longint mn, mx;
        mn = -longint'($urandom_range(50, 0));
        mx = longint'($urandom_range(50, 0));
        if ($urandom_range(7, 0) == 0) begin mn = 10; mx = -10; end
        cfg(c, longint'($urandom_range(160, 0)) - 80, longint'($urandom_range(40, 0)) - 20,
            mn, mx, int'($urandom_range(3, 0)));
        push_n(c, 60);
        acc_cnt[c] = 0;
      end
      enable = 4'b1111;
      for (int i = 0; i < 60; i++) begin
        out_ready = 1'($urandom_range(1, 0));
        tick();
      end
      for (int c = 0; c < 4; c++) chk($sformatf("rand_progress_ch%0d", c), acc_cnt[c] > 0, m_min[c] <= m_max[c]);
      stop_all();
    end

    // reset in the middle of a stream, with a done flag standing
    cfg(1, 0, 1, 0, 0, 1);
    push_n(1, 1);
    cfg(0, 0, 1, 0, 1000, 0);
    push_n(0, 100);
    out_ready = 1'b1;
    enable = 4'b0011;
    repeat (8) tick();
    chk("pre_reset_done", done[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_value", out_value, 0);
    chk("midrst_ch", out_ch, 0);
    enable = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      model_cfg(c, 0, 0, 0, 0, 0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_idle", out_valid, 0);

    // unconfigured channel after reset repeats 0; output registered one cycle
    push_n(3, 3);
    enable = 4'b1000;
    #0;
    chk("latency_pre", out_valid, 0);
    tick();
    chk("latency_valid", out_valid, 1);
    chk("latency_ch", out_ch, 3);
    wait_drain(3, 1, 50);
    enable = 4'b0000;
    tick(); tick();
    chk("step0_left", exp_q[3].size(), 0);
    out_ready = 1'b0;

    // 8-bit instance: wrap past the top without aliasing
    cfg8_we = 1'b1; cfg8_ch = 1'b0; cfg8_start = 8'sd120; cfg8_step = 8'sd10;
    cfg8_min = -8'sd128; cfg8_max = 8'sd127; cfg8_mode = 2'd0;
    tick();
    cfg8_we = 1'b0;
    exp8_q.push_back(120); exp8_q.push_back(-128);
    exp8_q.push_back(-118); exp8_q.push_back(-108);
    ready8 = 1'b1;
    enable8 = 2'b01;
    for (int i = 0; i < 50 && exp8_q.size() > 1; i++) tick();
    enable8 = 2'b00;
    tick(); tick(); tick();
    chk("w8_left", exp8_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
